// File: rtl/ms_ctrl.sv
// ms_ctrl: sequencing controller for the minesweeper datapath.
// Accepts new-game requests and cell selections, steps the datapath through
// start/load/decode/alu/display, latches the game result and counts moves.
// All state updates on the falling edge of clka; restart is synchronous.
// Optional watchdog: define MS_CTRL_WATCHDOG_EN to abort stuck done-waits
// into ERR after WD_CYCLES cycles. Without it the controller waits forever.
module ms_ctrl #(
    parameter int WD_CYCLES = 15
) (
    input  logic        clka,
    input  logic        restart,
    input  logic        new_game,
    input  logic        in_valid,
    input  logic [4:0]  in_cell,
    output logic        in_ready,
    output logic        bad_move,
    input  logic [24:0] cleared,
    input  logic        place_done,
    input  logic        alu_done,
    input  logic        display_done,
    input  logic        dp_gameover,
    input  logic        dp_win,
    output logic        start,
    output logic        load,
    output logic        decode,
    output logic        alu,
    output logic        display,
    output logic [4:0]  data,
    output logic        over,
    output logic        won,
    output logic [4:0]  moves,
    output logic        err
);

    typedef enum logic [3:0] {
        IDLE,
        PLACE,
        WAIT_IN,
        LOAD,
        DECODE,
        ALU,
        DISPLAY,
        OVER,
        ERR
    } state_t;

    localparam logic [4:0] MaxCell  = 5'd24;
    localparam logic [4:0] MaxMoves = 5'd25;

    state_t     state_q, state_d;
    logic [4:0] data_q, data_d;
    logic [4:0] moves_q, moves_d;
    logic       won_q, won_d;
    logic       gameOver_q, gameOver_d;
    logic       badMove_q, badMove_d;
    logic       cellBad;

    // A selection is rejected when it is off the board or already cleared;
    // the range test comes first so an off-board index never selects a bit.
    always_comb begin
        cellBad = 1'b0;
        if (in_cell > MaxCell) begin
            cellBad = 1'b1;
        end else begin
            cellBad = cleared[in_cell];
        end
    end

`ifdef MS_CTRL_WATCHDOG_EN
    localparam int WdW = (WD_CYCLES < 2) ? 1 : $clog2(WD_CYCLES + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(WD_CYCLES - 1);

    logic [WdW-1:0] wdCnt_q, wdCnt_d;
    logic           waiting;
`else
    logic unusedWdCfg;
    assign unusedWdCfg = (WD_CYCLES > 0);
`endif

    // Next-state and datapath-register update logic; every register holds
    // by default and only the transitions below change it.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        moves_d    = moves_q;
        won_d      = won_q;
        gameOver_d = gameOver_q;
        badMove_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (new_game) state_d = PLACE;
            end
            PLACE: begin
                if (place_done) state_d = WAIT_IN;
            end
            WAIT_IN: begin
                if (new_game) begin
                    state_d = PLACE;
                end else if (in_valid) begin
                    if (cellBad) begin
                        badMove_d = 1'b1;
                    end else begin
                        data_d  = in_cell;
                        moves_d = (moves_q == MaxMoves) ? MaxMoves : moves_q + 5'd1;
                        state_d = LOAD;
                    end
                end
            end
            LOAD: begin
                state_d = DECODE;
            end
            DECODE: begin
                state_d = ALU;
            end
            ALU: begin
                if (alu_done) begin
                    gameOver_d = dp_gameover;
                    won_d      = dp_win;
                    state_d    = DISPLAY;
                end
            end
            DISPLAY: begin
                if (display_done) state_d = gameOver_q ? OVER : WAIT_IN;
            end
            OVER: begin
                if (new_game) state_d = PLACE;
            end
            ERR: begin
                if (new_game) state_d = PLACE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == PLACE && state_q != PLACE) begin
            moves_d    = 5'd0;
            won_d      = 1'b0;
            gameOver_d = 1'b0;
        end

`ifdef MS_CTRL_WATCHDOG_EN
        waiting = ((state_q == PLACE)   && !place_done) ||
                  ((state_q == ALU)     && !alu_done)   ||
                  ((state_q == DISPLAY) && !display_done);
        wdCnt_d = '0;
        if (waiting) begin
            if (wdCnt_q == WdLast) begin
                state_d = ERR;
            end else begin
                wdCnt_d = wdCnt_q + 1'b1;
            end
        end
`endif
    end

    // State and datapath registers, updated on the falling edge.
    always_ff @(negedge clka) begin
        if (restart) begin
            state_q    <= IDLE;
            data_q     <= 5'd0;
            moves_q    <= 5'd0;
            won_q      <= 1'b0;
            gameOver_q <= 1'b0;
            badMove_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            moves_q    <= moves_d;
            won_q      <= won_d;
            gameOver_q <= gameOver_d;
            badMove_q  <= badMove_d;
        end
    end

`ifdef MS_CTRL_WATCHDOG_EN
    // Watchdog counter: restarts whenever a done-wait begins, counts while stalled.
    always_ff @(negedge clka) begin
        if (restart) begin
            wdCnt_q <= '0;
        end else begin
            wdCnt_q <= wdCnt_d;
        end
    end

    assign err = (state_q == ERR);
`else
    assign err = 1'b0;
`endif

    assign start    = (state_q == PLACE);
    assign load     = (state_q == LOAD);
    assign decode   = (state_q == DECODE);
    assign alu      = (state_q == ALU);
    assign display  = (state_q == DISPLAY);
    assign in_ready = (state_q == WAIT_IN);
    assign over     = (state_q == OVER);
    assign bad_move = badMove_q;
    assign data     = data_q;
    assign moves    = moves_q;
    assign won      = won_q;

endmodule

// File: doc/ms_ctrl.md
# ms_ctrl

Sequencing controller for the minesweeper datapath. `ms_ctrl` accepts new-game requests and user cell selections through a valid/ready handshake. It drives the datapath's `start`/`load`/`decode`/`alu`/`display` strobes in the required order and waits on the datapath's `place_done`/`alu_done`/`display_done` completions. It also latches the game result and counts accepted moves. It sits between the user-input front end and the datapath.

## Interface
- `WD_CYCLES`, default 15: watchdog limit in cycles for any done-wait (used only with the watchdog compiled in).
- Clocking/reset (already decided): one clock, `clka`; reset `restart` is synchronous and active-high.
- `clka`  in  1  clock; all state updates on negedge.
- `restart`  in  1  synchronous active-high reset.
- `new_game`  in  1  request a new game (level, sampled).
- `in_valid`  in  1  user cell selection valid.
- `in_cell`  in  5  user cell index, 0..24.
- `in_ready`  out  1  controller can accept a selection.
- `bad_move`  out  1  one-cycle pulse: handshake completed but the cell was rejected.
- `cleared`  in  25  datapath cleared-cell vector.
- `place_done`, `alu_done`, `display_done`  in  1 each  datapath completions.
- `dp_gameover`, `dp_win`  in  1 each  datapath result flags.
- `start`, `load`, `decode`, `alu`, `display`  out  1 each  datapath strobes.
- `data`  out  5  registered cell index to the datapath.
- `over`  out  1  game finished.
- `won`  out  1  finished game was a win; valid when `over`=1.
- `moves`  out  5  accepted moves this game.
- `err`  out  1  watchdog fired.

## Operation
- States: IDLE, PLACE, WAIT_IN, LOAD, DECODE, ALU, DISPLAY, OVER, ERR.
- All outputs are Moore outputs, registered or decoded from state only. At most one strobe is high in any cycle.
- **IDLE:** no strobes. `new_game`=1 → PLACE.
- **PLACE:** `start`=1. `place_done` → WAIT_IN. Entry clears `moves`, `won` and `over`.
- **WAIT_IN:** `in_ready`=1. On `in_valid`:
  - If `in_cell`>24 or `cleared[in_cell]`=1: pulse `bad_move`, stay in WAIT_IN, leave `moves` unchanged.
  - Otherwise: `data`←`in_cell`, `moves`+1, go to LOAD.
  - `new_game` has priority over `in_valid` → PLACE.
- **LOAD:** `load`=1 for exactly one cycle → DECODE.
- **DECODE:** `decode`=1 for exactly one cycle → ALU.
- **ALU:** `alu`=1 until `alu_done`. In the `alu_done` cycle, latch `dp_gameover`→`over_q` and `dp_win`→`won`, then go to DISPLAY.
- **DISPLAY:** `display`=1 until `display_done`. Then go to OVER if `over_q`, else WAIT_IN.
- **OVER:** `over`=1, `won` held. `new_game` → PLACE. `in_valid` is ignored and `in_ready`=0.
- **ERR:** `err`=1, no strobes. `new_game` → PLACE.
- `new_game` is ignored in PLACE, LOAD, DECODE, ALU and DISPLAY.
- `moves` saturates at 25 and never wraps.

## Timing
- **Reset:** `restart`=1 at a negedge forces:
  - state IDLE;
  - `data`=0, `moves`=0, `won`=0, `over`=0, `err`=0, `bad_move`=0;
  - all strobes 0, `in_ready`=0.
- `restart` overrides every input, including mid-ALU and mid-DISPLAY. The datapath is reset by the same signal.
- **Accept latency:** a selection accepted at edge N gives `load` high during cycle N+1, `decode` during N+2, and `alu` from N+3.
- **Done signals:** sampled at each negedge while waiting. A done already high on state entry advances on the first edge, giving a minimum of 1 cycle per state.
- **Back-to-back moves:** WAIT_IN is re-entered one cycle after `display_done`, so `in_ready` rises the next cycle.

## Configuration
- `MS_CTRL_WATCHDOG_EN` defined:
  - A cycle counter clears on entry to PLACE, ALU or DISPLAY and counts while waiting.
  - Reaching `WD_CYCLES` without the expected done → ERR.
- `MS_CTRL_WATCHDOG_EN` undefined:
  - The controller waits indefinitely, the counter is absent, and `err` is tied 0.

## Test plan
- **New game:** `restart`, then `new_game`; `place_done` one cycle after `start` → `in_ready`=1, `moves`=0, `over`=0.
- **Safe move:** `in_cell`=12, dones returned immediately, `dp_gameover`=0 → `load`/`decode`/`alu` at N+1/N+2/N+3 with `data`=12; `display`, then back to WAIT_IN with `moves`=1.
- **Rejects:**
  - `in_cell`=25 → one-cycle `bad_move` with no strobes.
  - `in_cell`=3 with `cleared[3]`=1 → same response.
  - In both cases `moves` is unchanged.
- **Mine hit:** `dp_gameover`=1, `dp_win`=0 at `alu_done` → after `display_done`: `over`=1, `won`=0, `in_valid` ignored. `new_game` → PLACE with `moves`=0.
- **Win:** `dp_gameover`=1, `dp_win`=1 → `over`=1, `won`=1.
- **Watchdog (`MS_CTRL_WATCHDOG_EN` defined, `WD_CYCLES`=15):** `alu_done` held low → `err`=1 after 15 cycles in ALU. `restart` mid-ALU → all outputs return to reset values on the next negedge.
